// File: rtl/spook_bus_pkg.sv
// Shared definitions for the Spook status-bus serializer: default bus width,
// bytes per word, byte-index width helper and serializer FSM states.
package spook_bus_pkg;

  localparam int BUS_SIZE_DEFAULT = 32;
  localparam int BYTES_PER_WORD   = BUS_SIZE_DEFAULT / 8;

  function automatic int idxWidth(input int bytesPerWord);
    return (bytesPerWord > 1) ? $clog2(bytesPerWord) : 1;
  endfunction

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } serState_e;

endpackage

// File: rtl/spook_ser_fifo.sv
// Word FIFO ahead of the serializer: stores each status word with its last flag
// and tracks its fill level to derive full/empty.
module spook_ser_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             last_i,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH:0]  mem_q [DEPTH];
  logic [PW-1:0]   wrPtr_q, rdPtr_q;
  logic [LW-1:0]   level_q;
  logic            doPush, doPop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PW'(1);
      case ({doPush, doPop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the level says they are valid.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= {last_i, data_i};
  end

  assign {last_o, data_o} = mem_q[rdPtr_q];

endmodule

// File: rtl/spook_out_serializer.sv
// Serializes Spook status-bus words into MSB-first bytes for the host.
// Define SPOOK_SER_BYTECNT_EN to add the per-message byte_count output.
module spook_out_serializer
  import spook_bus_pkg::*;
#(
  parameter int BUS_SIZE = BUS_SIZE_DEFAULT,
  parameter int DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BUS_SIZE-1:0] in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [7:0]          out_byte,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last
`ifdef SPOOK_SER_BYTECNT_EN
  ,
  output logic [15:0]         byte_count
`endif
);

  localparam int BPW   = BUS_SIZE / 8;
  localparam int IDX_W = idxWidth(BPW);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BPW - 1);

  serState_e             state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BUS_SIZE-1:0]   word_q, word_d;
  logic                  last_q, last_d;

  logic                  fifoPush, fifoPop, fifoFull, fifoEmpty, fifoLast;
  logic [BUS_SIZE-1:0]   fifoData;
  logic                  accept, byteFire, wordDone;

  spook_ser_fifo #(
    .WIDTH (BUS_SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifoPush),
    .pop_i   (fifoPop),
    .data_i  (in_data),
    .last_i  (in_last),
    .data_o  (fifoData),
    .last_o  (fifoLast),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // Gating with rst keeps in_ready low for the whole reset, not just after it.
  assign in_ready  = rst && !fifoFull;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == SER_SHIFT);
  assign byteFire  = out_valid && out_ready;
  assign wordDone  = byteFire && (idx_q == IDX_LAST);
  assign out_last  = out_valid && last_q && (idx_q == IDX_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SER_IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      last_q  <= last_d;
    end
  end

  // A new word is taken whenever the serializer is idle or finishing its last byte;
  // the FIFO head has priority, and only if it is empty does an incoming word bypass it.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    word_d   = word_q;
    last_d   = last_q;
    fifoPush = 1'b0;
    fifoPop  = 1'b0;
    if (byteFire) idx_d = idx_q + IDX_W'(1);
    if ((state_q == SER_IDLE) || wordDone) begin
      idx_d = '0;
      if (!fifoEmpty) begin
        word_d   = fifoData;
        last_d   = fifoLast;
        fifoPop  = 1'b1;
        fifoPush = accept;
        state_d  = SER_SHIFT;
      end else if (accept) begin
        word_d  = in_data;
        last_d  = in_last;
        state_d = SER_SHIFT;
      end else begin
        state_d = SER_IDLE;
      end
    end else begin
      fifoPush = accept;
    end
  end

  always_comb begin
    out_byte = '0;
    for (int i = 0; i < BPW; i++) begin
      if (idx_q == IDX_W'(i)) out_byte = word_q[BUS_SIZE-1-8*i -: 8];
    end
  end

`ifdef SPOOK_SER_BYTECNT_EN
  logic [15:0] byteCnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byteCnt_q <= '0;
    end else if (byteFire) begin
      if (out_last)                     byteCnt_q <= '0;
      else if (byteCnt_q != 16'hFFFF)   byteCnt_q <= byteCnt_q + 16'd1;
    end
  end

  assign byte_count = byteCnt_q;
`endif

endmodule

// File: tb/tb_spook_out_serializer.sv
// Directed scoreboard bench for spook_out_serializer (default BUS_SIZE=32, DEPTH=2);
// the byte-counter steps are built only when SPOOK_SER_BYTECNT_EN is defined.
module tb_spook_out_serializer;

  localparam int BPW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
`ifdef SPOOK_SER_BYTECNT_EN
  logic [15:0] byte_count;
`endif

  spook_out_serializer #(
    .BUS_SIZE (32),
    .DEPTH    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
`ifdef SPOOK_SER_BYTECNT_EN
    ,
    .byte_count (byte_count)
`endif
  );

  always #5 clk = ~clk;

  int         nChecks = 0;
  int         nFails = 0;
  int         outCount = 0;
  int         gaps = 0;
  logic [8:0] sbQ [$];
  logic       sampledValid, sampledReady, sampledLast, inAccepted, outFired;
  logic [7:0] sampledByte;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] data, input logic last, input logic valid, input logic ready);
    in_data   = data;
    in_last   = last;
    in_valid  = valid;
    out_ready = ready;
  endtask

  // Samples at the falling edge, scores output handshakes, records input handshakes,
  // then returns just after the next rising edge so stimulus can change.
  task automatic runCycle();
    logic [8:0]  exp;
    logic [31:0] w;
    @(negedge clk);
    sampledValid = out_valid;
    sampledReady = in_ready;
    sampledByte  = out_byte;
    sampledLast  = out_last;
    inAccepted   = in_valid && in_ready;
    outFired     = out_valid && out_ready;
    if (outFired) begin
      checkOutput("sbNotEmpty", 32'(sbQ.size() != 0), 32'd1);
      if (sbQ.size() != 0) begin
        exp = sbQ.pop_front();
        checkOutput("sbByte", {23'b0, out_last, out_byte}, {23'b0, exp});
      end
      outCount++;
    end
    if (inAccepted) begin
      for (int i = 0; i < BPW; i++) begin
        w = in_data << (8 * i);
        sbQ.push_back({in_last && (i == BPW - 1), w[31:24]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] words [3];
    words[0] = 32'h0A0B0C0D;
    words[1] = 32'h10203040;
    words[2] = 32'h55667788;

    // Reset state
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstInReady",  32'(in_ready),  32'd0);
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstOutLast",  32'(out_last),  32'd0);
    checkOutput("rstOutByte",  32'(out_byte),  32'd0);
    rst = 1'b1;
    runCycle();
    checkOutput("readyAfterReset", 32'(sampledReady), 32'd1);

    // Single word, one byte per cycle starting one cycle after acceptance
    $display("[TB] single word");
    outCount = 0;
    applyStimulus(32'hA1B2C3D4, 1'b1, 1'b1, 1'b1);
    runCycle();
    checkOutput("singleAccept", 32'(inAccepted), 32'd1);
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      runCycle();
      checkOutput("singleValid", 32'(sampledValid), 32'd1);
    end
    runCycle();
    checkOutput("singleIdle",  32'(sampledValid), 32'd0);
    checkOutput("singleCount", 32'(outCount), 32'd4);

    // Back-to-back words through a full FIFO
    $display("[TB] back-to-back");
    outCount = 0;
    gaps = 0;
    for (int w = 0; w < 3; w++) begin
      applyStimulus(words[w], w == 2, 1'b1, 1'b1);
      for (int t = 0; t < 10; t++) begin
        runCycle();
        if (outCount > 0 && outCount < 12 && !sampledValid) gaps++;
        if (inAccepted) break;
      end
      checkOutput("b2bAccept", 32'(inAccepted), 32'd1);
    end
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
    runCycle();
    checkOutput("b2bFull", 32'(sampledReady), 32'd0);
    for (int t = 0; t < 40 && outCount < 12; t++) begin
      runCycle();
      if (outCount > 0 && outCount < 12 && !sampledValid) gaps++;
    end
    checkOutput("b2bBytes", 32'(outCount), 32'd12);
    checkOutput("b2bGaps",  32'(gaps), 32'd0);
    runCycle();
    checkOutput("b2bRecover", 32'(sampledReady), 32'd1);
    checkOutput("b2bIdle",    32'(sampledValid), 32'd0);

    // Backpressure mid-word
    $display("[TB] backpressure");
    outCount = 0;
    applyStimulus(32'h11223344, 1'b1, 1'b1, 1'b1);
    runCycle();
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
    runCycle();
    runCycle();
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      runCycle();
      checkOutput("bpValid", 32'(sampledValid), 32'd1);
      checkOutput("bpByte",  32'(sampledByte),  32'h33);
      checkOutput("bpLast",  32'(sampledLast),  32'd0);
    end
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
    for (int t = 0; t < 10 && outCount < 4; t++) runCycle();
    checkOutput("bpBytes",   32'(outCount), 32'd4);
    checkOutput("bpDrained", 32'(sbQ.size()), 32'd0);

    // Reset while FIFO is full and byte index is 2
    $display("[TB] reset mid-operation");
    outCount = 0;
    applyStimulus(32'hAAAA0001, 1'b0, 1'b1, 1'b1);
    runCycle();
    applyStimulus(32'hAAAA0002, 1'b0, 1'b1, 1'b1);
    runCycle();
    applyStimulus(32'hAAAA0003, 1'b1, 1'b1, 1'b1);
    runCycle();
    checkOutput("midFillBytes", 32'(outCount), 32'd2);
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    #1;
    checkOutput("midRstValid", 32'(out_valid), 32'd0);
    checkOutput("midRstLast",  32'(out_last),  32'd0);
    checkOutput("midRstByte",  32'(out_byte),  32'd0);
    checkOutput("midRstReady", 32'(in_ready),  32'd0);
    sbQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    outCount = 0;
    runCycle();
    checkOutput("midRelReady", 32'(sampledReady), 32'd1);
    checkOutput("midRelValid", 32'(sampledValid), 32'd0);
    applyStimulus(32'h01020304, 1'b1, 1'b1, 1'b1);
    runCycle();
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
    runCycle();
    checkOutput("midFirstByte", 32'(sampledByte), 32'h01);
    for (int t = 0; t < 10 && outCount < 4; t++) runCycle();
    checkOutput("midBytes", 32'(outCount), 32'd4);

`ifdef SPOOK_SER_BYTECNT_EN
    // Per-message byte counter across a 2-word message
    $display("[TB] byte counter");
    outCount = 0;
    applyStimulus(32'hCAFEBABE, 1'b0, 1'b1, 1'b1);
    runCycle();
    applyStimulus(32'h12345678, 1'b1, 1'b1, 1'b1);
    runCycle();
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);
    for (int t = 0; t < 20 && outCount < 7; t++) runCycle();
    checkOutput("bcSeven",     32'(byte_count), 32'd7);
    checkOutput("bcLastShown", 32'(out_last),   32'd1);
    runCycle();
    checkOutput("bcClear",     32'(byte_count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
